// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller: forwarding, load-use stall, branch flush
//
// Purpose: resolves RAW hazards for the instruction in EX by forwarding from
// EX/MEM or MEM/WB (EX/MEM has priority), holds the front end for LOAD_LAT
// cycles on a load-use hazard, and holds FLUSH_MASK on the per-stage flush
// lines for FLUSH_CYCLES cycles after a taken branch. A taken branch always
// beats a stall.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ra, rb                source registers of the instruction in EX
//   rd_exmem, rd_memwb    destination registers held in EX/MEM and MEM/WB
//   wr_exmem, wr_memwb    the stage writes its destination
//   ld_exmem              EX/MEM holds a load
//   alu_result, wb_result candidate forwarded values
//   branch_taken          branch resolved taken this cycle
//   fa, fb                forwarded operand select
//   fwd_a, fwd_b          forwarded operand values
//   stall                 hold PC/IF/ID, bubble EX
//   flush                 per-stage flush
//   stall_cnt, flush_cnt  saturating activity counters (HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN

module hazard_ctrl_unit #(
    parameter int                  DATA_W       = 24,
    parameter int                  REG_W        = 4,
    parameter int                  N_STAGES     = 5,
    parameter int                  LOAD_LAT     = 1,
    parameter int                  FLUSH_CYCLES = 1,
    parameter logic [N_STAGES-1:0] FLUSH_MASK   = 5'b01110
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_W-1:0]    ra,
    input  logic [REG_W-1:0]    rb,
    input  logic [REG_W-1:0]    rd_exmem,
    input  logic [REG_W-1:0]    rd_memwb,
    input  logic                wr_exmem,
    input  logic                wr_memwb,
    input  logic                ld_exmem,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   wb_result,
    input  logic                branch_taken,
    output logic                fa,
    output logic                fb,
    output logic [DATA_W-1:0]   fwd_a,
    output logic [DATA_W-1:0]   fwd_b,
    output logic                stall,
    output logic [N_STAGES-1:0] flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The first cycle of each sequence is spent in IDLE, so the counter is
    // loaded with length-2 and the sequence ends when it reads zero.
    localparam logic [3:0] LOAD_RELOAD  = 4'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
    localparam logic [3:0] FLUSH_RELOAD = 4'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic hit_ex_a, hit_wb_a, hit_ex_b, hit_wb_b;
    logic lu;

    always_comb begin
        hit_ex_a = (ra == rd_exmem) && wr_exmem;
        hit_wb_a = (ra == rd_memwb) && wr_memwb;
        hit_ex_b = (rb == rd_exmem) && wr_exmem;
        hit_wb_b = (rb == rd_memwb) && wr_memwb;
        fa       = hit_ex_a || hit_wb_a;
        fb       = hit_ex_b || hit_wb_b;
        fwd_a    = hit_ex_a ? alu_result : wb_result;
        fwd_b    = hit_ex_b ? alu_result : wb_result;
        lu       = ld_exmem && ((ra == rd_exmem) || (rb == rd_exmem));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = '0;
        if (branch_taken) begin
            // Taken branch restarts the flush from any state and cancels a stall.
            flush = FLUSH_MASK;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (lu) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = LOAD_RELOAD;
                        end
                    end
                end
                ST_STALL: begin
                    stall = 1'b1;
                    if (cnt_q == 4'd0) state_d = ST_IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                ST_FLUSH: begin
                    flush = FLUSH_MASK;
                    if (cnt_q == 4'd0) state_d = ST_IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Control outputs are forced quiet during reset, whatever state holds.
        if (rst) begin
            stall = 1'b0;
            flush = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if ((|flush) && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

    localparam int         DW   = 24;
    localparam int         RW   = 4;
    localparam int         NS   = 5;
    localparam int         LL   = 3;
    localparam int         FC   = 2;
    localparam logic [4:0] MASK = 5'b01110;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] ra, rb, rd_exmem, rd_memwb;
    logic          wr_exmem, wr_memwb, ld_exmem, branch_taken;
    logic [DW-1:0] alu_result, wb_result;
    logic          fa, fb;
    logic [DW-1:0] fwd_a, fwd_b;
    logic          stall;
    logic [NS-1:0] flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cnt, flush_cnt;
`endif

    hazard_ctrl_unit #(
        .DATA_W(DW), .REG_W(RW), .N_STAGES(NS),
        .LOAD_LAT(LL), .FLUSH_CYCLES(FC), .FLUSH_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb),
        .rd_exmem(rd_exmem), .rd_memwb(rd_memwb),
        .wr_exmem(wr_exmem), .wr_memwb(wr_memwb), .ld_exmem(ld_exmem),
        .alu_result(alu_result), .wb_result(wb_result),
        .branch_taken(branch_taken),
        .fa(fa), .fb(fb), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .flush(flush)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: remaining stall / flush cycles as plain integers.
    int            m_stall_left = 0, m_flush_left = 0;
    int            n_stall_left, n_flush_left;
    longint        m_scnt = 0, m_fcnt = 0;
    logic          e_stall, e_fa, e_fb;
    logic [NS-1:0] e_flush;
    logic [DW-1:0] e_fwd_a, e_fwd_b;

    task automatic eval_model();
        logic lu;
        lu = ld_exmem && (ra == rd_exmem || rb == rd_exmem);
        // Youngest producer wins: EX/MEM first, otherwise the MEM/WB value.
        e_fa    = (wr_exmem && ra == rd_exmem) || (wr_memwb && ra == rd_memwb);
        e_fb    = (wr_exmem && rb == rd_exmem) || (wr_memwb && rb == rd_memwb);
        e_fwd_a = (wr_exmem && ra == rd_exmem) ? alu_result : wb_result;
        e_fwd_b = (wr_exmem && rb == rd_exmem) ? alu_result : wb_result;
        e_stall = 1'b0;
        e_flush = '0;
        n_stall_left = m_stall_left;
        n_flush_left = m_flush_left;
        if (rst) begin
            n_stall_left = 0;
            n_flush_left = 0;
        end else if (branch_taken) begin
            e_flush      = MASK;
            n_flush_left = FC - 1;
            n_stall_left = 0;
        end else if (m_flush_left > 0) begin
            e_flush      = MASK;
            n_flush_left = m_flush_left - 1;
        end else if (m_stall_left > 0) begin
            e_stall      = 1'b1;
            n_stall_left = m_stall_left - 1;
        end else if (lu) begin
            e_stall      = 1'b1;
            n_stall_left = LL - 1;
        end
    endtask

    task automatic settle();
        #1;
        eval_model();
    endtask

    task automatic advance();
        @(posedge clk);
        m_stall_left = n_stall_left;
        m_flush_left = n_flush_left;
        if (rst) begin
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (e_stall)  m_scnt++;
            if (|e_flush) m_fcnt++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        ra = '0; rb = '0; rd_exmem = 4'd9; rd_memwb = 4'd10;
        wr_exmem = 1'b0; wr_memwb = 1'b0; ld_exmem = 1'b0; branch_taken = 1'b0;
        alu_result = '0; wb_result = '0;
    endtask

    task automatic drain();
        clear_inputs();
        for (int i = 0; i < 20 && (m_stall_left > 0 || m_flush_left > 0); i++) begin
            settle();
            advance();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ld_exmem = 1'b1; rd_exmem = 4'd3; ra = 4'd3; wr_exmem = 1'b1;
        alu_result = 24'h123456;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (stall !== 1'b0 || flush !== 5'b0)
                $display("FAIL reset_ctl cyc%0d stall=%b flush=%b required 0/00000", i, stall, flush);
            else passed++;
            total++;
            if (fa !== 1'b1 || fwd_a !== 24'h123456)
                $display("FAIL reset_fwd fa=%b fwd_a=%h required 1/123456", fa, fwd_a);
            else passed++;
            advance();
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL reset_perf stall_cnt=%0d flush_cnt=%0d required 0/0", stall_cnt, flush_cnt);
        else passed++;
`endif
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        ra = 4'd3; rb = 4'd3; rd_exmem = 4'd3; rd_memwb = 4'd3;
        wr_exmem = 1'b1; wr_memwb = 1'b1;
        alu_result = 24'h00AAAA; wb_result = 24'h000055;
        #1;
        total++;
        if (fa !== 1'b1 || fwd_a !== 24'h00AAAA || fb !== 1'b1 || fwd_b !== 24'h00AAAA)
            $display("FAIL fwd_both fa=%b fwd_a=%h fb=%b fwd_b=%h required 1/00aaaa", fa, fwd_a, fb, fwd_b);
        else passed++;
        wr_exmem = 1'b0;
        #1;
        total++;
        if (fa !== 1'b1 || fwd_a !== 24'h000055 || fwd_b !== 24'h000055)
            $display("FAIL fwd_wb fa=%b fwd_a=%h fwd_b=%h required 1/000055", fa, fwd_a, fwd_b);
        else passed++;
        wr_memwb = 1'b0;
        #1;
        total++;
        if (fa !== 1'b0 || fb !== 1'b0)
            $display("FAIL fwd_none fa=%b fb=%b required 0", fa, fb);
        else passed++;
        rb = 4'd7; wr_memwb = 1'b1; rd_memwb = 4'd7;
        #1;
        total++;
        if (fa !== 1'b0 || fb !== 1'b1 || fwd_b !== 24'h000055)
            $display("FAIL fwd_b_only fa=%b fb=%b fwd_b=%h required 0/1/000055", fa, fb, fwd_b);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_load_use();
        int n_stall = 0;
        clear_inputs();
        ld_exmem = 1'b1; rd_exmem = 4'd5; rb = 4'd5;
        for (int i = 0; i < 6; i++) begin
            settle();
            total++;
            if (stall !== e_stall || flush !== e_flush)
                $display("FAIL load_use cyc%0d stall=%b flush=%b required %b/%b", i, stall, flush, e_stall, e_flush);
            else passed++;
            if (stall === 1'b1) n_stall++;
            advance();
            ld_exmem = 1'b0;
        end
        total++;
        if (n_stall != LL)
            $display("FAIL load_use_len stall cycles=%0d required %0d", n_stall, LL);
        else passed++;
    endtask

    task automatic test_branch_flush();
        int n_flush = 0;
        clear_inputs();
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if (stall !== 1'b0 || flush !== e_flush)
                $display("FAIL branch cyc%0d stall=%b flush=%b required 0/%b", i, stall, flush, e_flush);
            else passed++;
            if (flush === MASK) n_flush++;
            advance();
            branch_taken = 1'b0;
        end
        total++;
        if (n_flush != FC)
            $display("FAIL branch_len flush cycles=%0d required %0d", n_flush, FC);
        else passed++;
    endtask

    task automatic test_branch_during_stall();
        clear_inputs();
        ld_exmem = 1'b1; rd_exmem = 4'd2; ra = 4'd2;
        settle();
        advance();
        ld_exmem = 1'b0;
        branch_taken = 1'b1;
        settle();
        total++;
        if (stall !== 1'b0 || flush !== MASK)
            $display("FAIL br_in_stall stall=%b flush=%b required 0/%b", stall, flush, MASK);
        else passed++;
        advance();
        branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if (stall !== 1'b0 || flush !== e_flush)
                $display("FAIL br_in_stall_after cyc%0d stall=%b flush=%b required 0/%b", i, stall, flush, e_flush);
            else passed++;
            advance();
        end
    endtask

    task automatic test_lu_and_branch();
        clear_inputs();
        ld_exmem = 1'b1; rd_exmem = 4'd6; ra = 4'd6; branch_taken = 1'b1;
        settle();
        total++;
        if (stall !== 1'b0 || flush !== MASK)
            $display("FAIL lu_and_branch stall=%b flush=%b required 0/%b", stall, flush, MASK);
        else passed++;
        advance();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        ld_exmem = 1'b1; rd_exmem = 4'd4; rb = 4'd4;
        settle();
        advance();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (stall !== 1'b0 || flush !== 5'b0)
                $display("FAIL rst_mid_stall cyc%0d stall=%b flush=%b required 0", i, stall, flush);
            else passed++;
            advance();
        end
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (stall !== 1'b0 || flush !== 5'b0)
                $display("FAIL after_rst cyc%0d stall=%b flush=%b required 0", i, stall, flush);
            else passed++;
            advance();
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cnt !== 32'd0)
            $display("FAIL perf_after_rst stall_cnt=%0d required 0", stall_cnt);
        else passed++;
        ld_exmem = 1'b1; rd_exmem = 4'd4; rb = 4'd4;
        settle();
        advance();
        drain();
        settle();
        total++;
        if (stall_cnt !== 32'd3)
            $display("FAIL perf_one_stall stall_cnt=%0d required 3", stall_cnt);
        else passed++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            ra           = 4'($urandom_range(0, 3));
            rb           = 4'($urandom_range(0, 3));
            rd_exmem     = 4'($urandom_range(0, 3));
            rd_memwb     = 4'($urandom_range(0, 3));
            wr_exmem     = 1'($urandom_range(0, 1));
            wr_memwb     = 1'($urandom_range(0, 1));
            ld_exmem     = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            alu_result   = 24'($urandom);
            wb_result    = 24'($urandom);
            settle();
            total++;
            if (fa !== e_fa || fb !== e_fb || fwd_a !== e_fwd_a || fwd_b !== e_fwd_b ||
                stall !== e_stall || flush !== e_flush || (stall === 1'b1 && flush !== 5'b0))
                $display("FAIL random cyc%0d fa=%b fb=%b fwd_a=%h fwd_b=%h stall=%b flush=%b required %b %b %h %h %b %b",
                         i, fa, fb, fwd_a, fwd_b, stall, flush, e_fa, e_fb, e_fwd_a, e_fwd_b, e_stall, e_flush);
            else passed++;
`ifdef HAZARD_PERF_CNT_EN
            total++;
            if (stall_cnt !== 32'(m_scnt) || flush_cnt !== 32'(m_fcnt))
                $display("FAIL random_perf cyc%0d stall_cnt=%0d flush_cnt=%0d required %0d/%0d",
                         i, stall_cnt, flush_cnt, m_scnt, m_fcnt);
            else passed++;
`endif
            advance();
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_flush();
        test_branch_during_stall();
        test_lu_and_branch();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
